// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-address ROM among r requesters.
// One grant per clock; a requester served this cycle is masked from the next grant.
module rom_arbiter #(
    parameter int r = 4,
    parameter int n = 8,
    parameter int m = 512,
    localparam int a  = $clog2(m),
    localparam int PW = $clog2(r)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [r-1:0]   req_i,
    input  logic [r*a-1:0] addr_i,
    output logic [r-1:0]   valid_o,
    output logic [n-1:0]   data_o,
    output logic [a-1:0]   rom_addr_o,
    input  logic [n-1:0]   rom_data_i
);

    logic [PW-1:0] p_q, p_d;
    logic [r-1:0]  valid_q, valid_d;
    logic [a-1:0]  last_addr_q, last_addr_d;

    logic [r-1:0]  elig;
    logic          any_w;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic [a-1:0]  win_addr;

    // Search upward from the pointer, wrapping at r-1.
    always_comb begin
        elig  = req_i & ~valid_q;
        any_w = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < r; i++) begin
            idx = PW'((int'(p_q) + i) % r);
            if (!any_w && elig[idx]) begin
                any_w = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        valid_d  = '0;
        for (int k = 0; k < r; k++) begin
            if (win == PW'(k)) begin
                win_addr   = addr_i[k*a +: a];
                valid_d[k] = any_w;
            end
        end
        p_d         = p_q;
        last_addr_d = last_addr_q;
        if (any_w) begin
            p_d         = (win == PW'(r-1)) ? '0 : win + 1'b1;
            last_addr_d = win_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            valid_q     <= '0;
            last_addr_q <= '0;
        end else begin
            p_q         <= p_d;
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign rom_addr_o = any_w ? win_addr : last_addr_q;
    assign valid_o    = valid_q;
    assign data_o     = rom_data_i;

endmodule
